// File: rtl/ibex_l2_rf_xfer_ctrl_pkg.sv
// Shared types for the L2 <-> core register-file context transfer sequencer.
package ibex_l2_rf_xfer_ctrl_pkg;

  localparam int unsigned L2XferAddrW = 5;

  typedef enum logic [1:0] {
    XFER_SPILL = 2'b00,
    XFER_FILL  = 2'b01,
    XFER_SWAP  = 2'b10
  } l2_xfer_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPILL,
    ST_FILL,
    ST_DRAIN,
    ST_SWAP_RD,
    ST_SWAP_WR
  } l2_xfer_state_e;

  function automatic logic [L2XferAddrW-1:0] xfer_idx_inc(input logic [L2XferAddrW-1:0] idx);
    return idx + L2XferAddrW'(1);
  endfunction

endpackage

// File: rtl/ibex_l2_rf_xfer_ctrl.sv
// Moves whole register contexts between the core RF and the L2 RF (spill, fill, swap).
// x0 is never touched; all outputs are registered and the write enables drop while rst_i is high.
module ibex_l2_rf_xfer_ctrl
  import ibex_l2_rf_xfer_ctrl_pkg::*;
#(
  parameter int unsigned NumWords  = 32,
  parameter int unsigned DataWidth = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [1:0]             op_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [4:0]             rf_raddr_o,
  input  logic [DataWidth-1:0]   rf_rdata_i,
  output logic [4:0]             rf_waddr_o,
  output logic [DataWidth-1:0]   rf_wdata_o,
  output logic                   rf_we_o,
  output logic [4:0]             l2_addr_o,
  output logic [DataWidth-1:0]   l2_wdata_o,
  input  logic [DataWidth-1:0]   l2_rdata_i,
  output logic                   l2_we_o
);

  localparam logic [L2XferAddrW-1:0] FirstIdx = L2XferAddrW'(1);
  localparam logic [L2XferAddrW-1:0] LastIdx  = L2XferAddrW'(NumWords - 1);

  l2_xfer_state_e             state_q, state_d;
  logic [L2XferAddrW-1:0]     idx_q, idx_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;
  logic [L2XferAddrW-1:0]     rf_raddr_q, rf_raddr_d;
  logic [L2XferAddrW-1:0]     rf_waddr_q, rf_waddr_d;
  logic [DataWidth-1:0]       rf_wdata_q, rf_wdata_d;
  logic                       rf_we_q, rf_we_d;
  logic [L2XferAddrW-1:0]     l2_addr_q, l2_addr_d;
  logic [DataWidth-1:0]       l2_wdata_q, l2_wdata_d;
  logic                       l2_we_q, l2_we_d;

  // The write-side output registers double as the single pipeline stage.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    rf_raddr_d = '0;
    rf_waddr_d = '0;
    rf_wdata_d = '0;
    rf_we_d    = 1'b0;
    l2_addr_d  = '0;
    l2_wdata_d = '0;
    l2_we_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          case (op_i)
            XFER_SPILL: begin
              state_d    = ST_SPILL;
              idx_d      = FirstIdx;
              busy_d     = 1'b1;
              rf_raddr_d = FirstIdx;
            end
            XFER_FILL: begin
              state_d   = ST_FILL;
              idx_d     = FirstIdx;
              busy_d    = 1'b1;
              l2_addr_d = FirstIdx;
            end
            XFER_SWAP: begin
              state_d    = ST_SWAP_RD;
              idx_d      = FirstIdx;
              busy_d     = 1'b1;
              rf_raddr_d = FirstIdx;
              l2_addr_d  = FirstIdx;
            end
            default: begin
              done_d = 1'b1;
              err_d  = 1'b1;
            end
          endcase
        end
      end
      ST_SPILL: begin
        busy_d     = 1'b1;
        l2_we_d    = 1'b1;
        l2_addr_d  = idx_q;
        l2_wdata_d = rf_rdata_i;
        if (idx_q == LastIdx) begin
          state_d = ST_DRAIN;
        end else begin
          idx_d      = xfer_idx_inc(idx_q);
          rf_raddr_d = xfer_idx_inc(idx_q);
        end
      end
      ST_FILL: begin
        busy_d     = 1'b1;
        rf_we_d    = 1'b1;
        rf_waddr_d = idx_q;
        rf_wdata_d = l2_rdata_i;
        if (idx_q == LastIdx) begin
          state_d = ST_DRAIN;
        end else begin
          idx_d     = xfer_idx_inc(idx_q);
          l2_addr_d = xfer_idx_inc(idx_q);
        end
      end
      ST_DRAIN: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        done_d  = 1'b1;
      end
      // Both read values are held in the write registers, so the exchange needs no temp.
      ST_SWAP_RD: begin
        state_d    = ST_SWAP_WR;
        busy_d     = 1'b1;
        l2_we_d    = 1'b1;
        l2_addr_d  = idx_q;
        l2_wdata_d = rf_rdata_i;
        rf_we_d    = 1'b1;
        rf_waddr_d = idx_q;
        rf_wdata_d = l2_rdata_i;
      end
      ST_SWAP_WR: begin
        if (idx_q == LastIdx) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          state_d    = ST_SWAP_RD;
          idx_d      = xfer_idx_inc(idx_q);
          busy_d     = 1'b1;
          rf_raddr_d = xfer_idx_inc(idx_q);
          l2_addr_d  = xfer_idx_inc(idx_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rf_raddr_q <= '0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      rf_we_q    <= 1'b0;
      l2_addr_q  <= '0;
      l2_wdata_q <= '0;
      l2_we_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rf_raddr_q <= rf_raddr_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      rf_we_q    <= rf_we_d;
      l2_addr_q  <= l2_addr_d;
      l2_wdata_q <= l2_wdata_d;
      l2_we_q    <= l2_we_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign rf_raddr_o = rf_raddr_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;
  assign l2_addr_o  = l2_addr_q;
  assign l2_wdata_o = l2_wdata_q;
  // A reset aborts at once: the write pending in the reset cycle must not land.
  assign rf_we_o    = rf_we_q & ~rst_i;
  assign l2_we_o    = l2_we_q & ~rst_i;

endmodule

// File: tb/tb_ibex_l2_rf_xfer_ctrl.sv
// Bench for ibex_l2_rf_xfer_ctrl: behavioural schedule model plus RF/L2 memories.
module tb_ibex_l2_rf_xfer_ctrl;

  localparam int N  = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic [1:0]    op_i = 2'b00;
  logic          busy_o, done_o, err_o;
  logic [4:0]    rf_raddr_o, rf_waddr_o, l2_addr_o;
  logic [DW-1:0] rf_rdata_i, rf_wdata_o, l2_wdata_o, l2_rdata_i;
  logic          rf_we_o, l2_we_o;

  logic [DW-1:0] core_mem [N];
  logic [DW-1:0] l2_mem   [N];
  logic [DW-1:0] core_init[N];
  logic [DW-1:0] l2_init  [N];
  logic          init_req = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  bit            act = 1'b0;
  bit            armed = 1'b0;
  int            t0 = 0;
  logic [1:0]    mop = 2'b00;
  logic [DW-1:0] snap_core[N];
  logic [DW-1:0] snap_l2  [N];

  ibex_l2_rf_xfer_ctrl #(.NumWords(N), .DataWidth(DW)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .rf_raddr_o(rf_raddr_o), .rf_rdata_i(rf_rdata_i),
    .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .rf_we_o(rf_we_o),
    .l2_addr_o(l2_addr_o), .l2_wdata_o(l2_wdata_o), .l2_rdata_i(l2_rdata_i),
    .l2_we_o(l2_we_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rf_rdata_i = core_mem[rf_raddr_o];
  assign l2_rdata_i = l2_mem[l2_addr_o];

  always @(posedge clk) begin
    if (init_req) begin
      core_mem <= core_init;
      l2_mem   <= l2_init;
    end else begin
      if (rf_we_o) core_mem[rf_waddr_o] <= rf_wdata_o;
      if (l2_we_o) l2_mem[l2_addr_o] <= l2_wdata_o;
    end
  end

  function automatic int done_off(input logic [1:0] op);
    case (op)
      2'd0, 2'd1: return N + 1;
      2'd2:       return 2 * N - 1;
      default:    return 1;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  // Expected memories after m registers of the current op have been transferred.
  task automatic mem_check(input int m);
    logic [DW-1:0] ec[N];
    logic [DW-1:0] el[N];
    int bc, bl;
    ec = snap_core;
    el = snap_l2;
    for (int i = 1; i <= m; i++) begin
      if (mop == 2'd0 || mop == 2'd2) el[i] = snap_core[i];
      if (mop == 2'd1 || mop == 2'd2) ec[i] = snap_l2[i];
    end
    bc = -1;
    bl = -1;
    for (int i = 0; i < N; i++) begin
      if (core_mem[i] !== ec[i]) bc = i;
      if (l2_mem[i] !== el[i]) bl = i;
    end
    checks += 2;
    if (bc >= 0) begin
      failures++;
      $display("FAIL core_mem op=%0d idx=%0d got=%h expected=%h", mop, bc, core_mem[bc], ec[bc]);
    end
    if (bl >= 0) begin
      failures++;
      $display("FAIL l2_mem op=%0d idx=%0d got=%h expected=%h", mop, bl, l2_mem[bl], el[bl]);
    end
  endtask

  // Runs at the falling edge: compare this cycle's outputs, then advance the model.
  task automatic model_check();
    logic          e_busy, e_done, e_err, e_rfwe, e_l2we, ign;
    logic [4:0]    e_rra, e_rwa, e_la, g_rra;
    logic [DW-1:0] e_rwd, e_lwd;
    logic [83:0]   ev, gv;
    int d, k, m;
    {e_busy, e_done, e_err, e_rfwe, e_l2we, ign} = '0;
    e_rra = '0; e_rwa = '0; e_la = '0; e_rwd = '0; e_lwd = '0;
    d = cyc - t0;
    if (act && d >= 1 && d <= done_off(mop)) begin
      case (mop)
        2'd0: begin
          e_busy = (d <= N);
          if (d <= N - 1) e_rra = 5'(d);
          if (d >= 2 && d <= N) begin
            e_l2we = 1'b1; e_la = 5'(d - 1); e_lwd = snap_core[d-1];
          end
          e_done = (d == N + 1);
        end
        2'd1: begin
          e_busy = (d <= N);
          if (d <= N - 1) e_la = 5'(d);
          if (d >= 2 && d <= N) begin
            e_rfwe = 1'b1; e_rwa = 5'(d - 1); e_rwd = snap_l2[d-1];
          end
          e_done = (d == N + 1);
        end
        2'd2: begin
          e_busy = (d <= 2 * N - 2);
          if (d <= 2 * N - 2) begin
            if (d % 2 == 1) begin
              k = (d + 1) / 2;
              e_rra = 5'(k); e_la = 5'(k);
            end else begin
              k = d / 2;
              ign = 1'b1;
              e_la = 5'(k); e_rwa = 5'(k);
              e_rfwe = 1'b1; e_l2we = 1'b1;
              e_lwd = snap_core[k]; e_rwd = snap_l2[k];
            end
          end
          e_done = (d == 2 * N - 1);
        end
        default: begin
          e_done = 1'b1; e_err = 1'b1;
        end
      endcase
    end
    if (rst_i) begin
      e_rfwe = 1'b0; e_l2we = 1'b0;
    end
    g_rra = ign ? 5'd0 : rf_raddr_o;
    ev = {e_busy, e_done, e_err, e_rra, e_rwa, e_rwd, e_rfwe, e_la, e_lwd, e_l2we};
    gv = {busy_o, done_o, err_o, g_rra, rf_waddr_o, rf_wdata_o, rf_we_o, l2_addr_o, l2_wdata_o, l2_we_o};
    if (armed) begin
      checks++;
      if (gv !== ev) begin
        failures++;
        $display("FAIL cycle_outputs cyc=%0d op=%0d off=%0d got=%h expected=%h", cyc, mop, d, gv, ev);
      end
    end
    if (rst_i) begin
      if (act && armed && d < done_off(mop)) begin
        if (mop == 2'd2) m = (d - 1) / 2;
        else if (mop == 2'd3) m = 0;
        else m = d - 2;
        if (m < 0) m = 0;
        if (m > N - 1) m = N - 1;
        mem_check(m);
      end
      act = 1'b0;
      armed = 1'b1;
    end else begin
      if (act && armed && d == done_off(mop)) mem_check(mop == 2'd3 ? 0 : N - 1);
      if ((!act || d >= done_off(mop)) && start_i) begin
        act = 1'b1;
        t0 = cyc;
        mop = op_i;
        snap_core = core_mem;
        snap_l2 = l2_mem;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mems();
    init_req = 1'b1;
    step();
    init_req = 1'b0;
  endtask

  task automatic launch(input logic [1:0] op, output int ts);
    start_i = 1'b1;
    op_i = op;
    ts = cyc;
    step();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int ts, output int off);
    off = -1;
    for (int i = 0; i < 200; i++) begin
      if (done_o) begin
        off = cyc - ts;
        break;
      end
      step();
    end
  endtask

  initial begin
    int ts, off, len;
    for (int i = 0; i < N; i++) begin
      core_init[i] = '0; l2_init[i] = '0;
    end
    repeat (3) step();
    rst_i = 1'b0;
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_we", 32'({rf_we_o, l2_we_o, done_o}), 32'd0);

    // Spill
    for (int i = 0; i < N; i++) begin
      core_init[i] = 32'hA000_0000 + 32'(i); l2_init[i] = 32'h0;
    end
    load_mems();
    launch(2'b00, ts);
    wait_done(ts, off);
    chk("spill_done_off", 32'(off), 32'd33);
    chk("spill_l2_x5", l2_mem[5], 32'hA000_0005);
    chk("spill_l2_x31", l2_mem[31], 32'hA000_001F);
    chk("spill_l2_x0", l2_mem[0], 32'h0);

    // Fill with an ignored start at T+5
    for (int i = 0; i < N; i++) begin
      l2_init[i] = 32'h5A00_0000 | 32'(i); core_init[i] = 32'hC0DE_0000 + 32'(i);
    end
    load_mems();
    launch(2'b01, ts);
    repeat (4) step();
    start_i = 1'b1; op_i = 2'b10;
    step();
    start_i = 1'b0;
    wait_done(ts, off);
    chk("fill_done_off", 32'(off), 32'd33);
    chk("fill_core_x31", core_mem[31], 32'h5A00_001F);
    chk("fill_core_x0", core_mem[0], 32'hC0DE_0000);

    // Swap
    for (int i = 0; i < N; i++) begin
      core_init[i] = 32'(i); l2_init[i] = 32'h100 + 32'(i);
    end
    load_mems();
    launch(2'b10, ts);
    wait_done(ts, off);
    chk("swap_done_off", 32'(off), 32'd63);
    chk("swap_core_x3", core_mem[3], 32'h103);
    chk("swap_l2_x3", l2_mem[3], 32'h3);

    // Reserved op
    launch(2'b11, ts);
    chk("rsv_done_err", 32'({done_o, err_o}), 32'd3);
    chk("rsv_busy_we", 32'({busy_o, rf_we_o, l2_we_o}), 32'd0);

    // Back-to-back spills with start held high
    start_i = 1'b1; op_i = 2'b00; ts = cyc;
    step();
    wait_done(ts, off);
    chk("b2b_first_done", 32'(off), 32'd33);
    step();
    wait_done(ts, off);
    start_i = 1'b0;
    chk("b2b_second_done", 32'(off), 32'd66);
    step();

    // Reset in the middle of a spill
    for (int i = 0; i < N; i++) begin
      core_init[i] = 32'hA000_0000 + 32'(i); l2_init[i] = 32'hB000_0000 + 32'(i);
    end
    load_mems();
    launch(2'b00, ts);
    repeat (9) step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("rst_outputs", 32'({busy_o, done_o, rf_we_o, l2_we_o, rf_raddr_o, l2_addr_o}), 32'd0);
    chk("rst_l2_x8", l2_mem[8], 32'hA000_0008);
    chk("rst_l2_x9", l2_mem[9], 32'hB000_0009);
    repeat (5) step();

    // Randomized traffic: stray starts, random ops, occasional resets
    for (int it = 0; it < 14; it++) begin
      for (int i = 0; i < N; i++) begin
        core_init[i] = $urandom; l2_init[i] = $urandom;
      end
      load_mems();
      launch(2'($urandom_range(0, 3)), ts);
      len = $urandom_range(5, 75);
      for (int j = 0; j < len; j++) begin
        start_i = ($urandom_range(0, 7) == 0);
        op_i = 2'($urandom_range(0, 3));
        rst_i = ($urandom_range(0, 59) == 0);
        step();
      end
      start_i = 1'b0; rst_i = 1'b0;
      step();
      for (int j = 0; j < 100 && busy_o; j++) step();
      if (busy_o) chk("busy_timeout", 32'(busy_o), 32'd0);
    end
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
